// File: rtl/force_step_sequencer.sv
// Time-multiplexes one shared force calculator across all bodies: per object it issues every
// other-body index, accumulates the returned forces and commits a saturated sum to the bank.
// Optional build macro FORCE_SEQ_OVERRUN_CNT_EN enables the dropped-step-request counter.
module force_step_sequencer #(
  parameter int N_OBJ      = 8,
  parameter int SEL_W      = 3,
  parameter int FORCE_W    = 14,
  parameter int FC_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step_req,
  output logic               step_busy,
  output logic               step_done,
  output logic [SEL_W-1:0]   obj_sel,
  output logic [SEL_W-1:0]   other_sel,
  output logic               fc_issue,
  input  logic [FORCE_W-1:0] x_force_in,
  input  logic [FORCE_W-1:0] y_force_in,
  output logic [FORCE_W-1:0] x_force_sum,
  output logic [FORCE_W-1:0] y_force_sum,
  output logic               commit,
  output logic [SEL_W-1:0]   commit_sel,
  output logic [7:0]         overrun_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

  localparam int ACC_W = FORCE_W + SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N_OBJ - 1);
  localparam logic [7:0]       DRAIN_LAST = 8'(FC_LATENCY - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(SEL_W+1){1'b0}}, {(FORCE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(SEL_W+1){1'b1}}, {(FORCE_W-1){1'b0}}};

  state_t               state_q;
  logic [SEL_W-1:0]     obj_sel_q, other_sel_q, commit_sel_q;
  logic                 fc_issue_q, busy_q, done_q, commit_q;
  logic [FORCE_W-1:0]   x_sum_q, y_sum_q;
  logic [7:0]           drain_cnt_q;
  logic signed [ACC_W-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
  logic signed [ACC_W-1:0] x_ext, y_ext;
  logic                 acc_en, first_issue, to_commit;

  function automatic logic [FORCE_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return {1'b0, {(FORCE_W-1){1'b1}}};
    else if (a < SAT_MIN) return {1'b1, {(FORCE_W-1){1'b0}}};
    else                  return a[FORCE_W-1:0];
  endfunction

  assign x_ext = {{SEL_W{x_force_in[FORCE_W-1]}}, x_force_in};
  assign y_ext = {{SEL_W{y_force_in[FORCE_W-1]}}, y_force_in};

  // The in-flight valid pipe is the sole accumulate enable; latency 0 uses the issue itself.
  if (FC_LATENCY == 0) begin : g_comb
    assign acc_en = fc_issue_q;
  end else begin : g_pipe
    logic [FC_LATENCY-1:0] vld_q;
    logic [FC_LATENCY:0]   vld_shift;
    assign vld_shift = {vld_q, fc_issue_q};
    always_ff @(posedge clock) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_shift[FC_LATENCY-1:0];
    end
    assign acc_en = vld_q[FC_LATENCY-1];
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    first_issue = fc_issue_q && (other_sel_q == '0);
    to_commit   = 1'b0;
    if (state_q == S_ISSUE && other_sel_q == LAST_SEL && FC_LATENCY == 0) to_commit = 1'b1;
    if (state_q == S_DRAIN && drain_cnt_q == DRAIN_LAST)                  to_commit = 1'b1;
    acc_x_d = (first_issue ? '0 : acc_x_q) + (acc_en ? x_ext : '0);
    acc_y_d = (first_issue ? '0 : acc_y_q) + (acc_en ? y_ext : '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      obj_sel_q    <= '0;
      other_sel_q  <= '0;
      commit_sel_q <= '0;
      fc_issue_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      commit_q     <= 1'b0;
      x_sum_q      <= '0;
      y_sum_q      <= '0;
      drain_cnt_q  <= '0;
    end else begin
      commit_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (step_req) begin
            state_q     <= S_ISSUE;
            obj_sel_q   <= '0;
            other_sel_q <= '0;
            fc_issue_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (other_sel_q == LAST_SEL) begin
            fc_issue_q  <= 1'b0;
            other_sel_q <= '0;
            drain_cnt_q <= '0;
            state_q     <= (FC_LATENCY == 0) ? S_COMMIT : S_DRAIN;
          end else begin
            other_sel_q <= other_sel_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) state_q <= S_COMMIT;
          else                           drain_cnt_q <= drain_cnt_q + 8'd1;
        end
        S_COMMIT: begin
          if (obj_sel_q == LAST_SEL) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            obj_sel_q  <= obj_sel_q + 1'b1;
            fc_issue_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // The sum includes any result arriving in the same cycle the FSM heads into COMMIT.
      if (to_commit) begin
        commit_q     <= 1'b1;
        commit_sel_q <= obj_sel_q;
        x_sum_q      <= sat(acc_x_d);
        y_sum_q      <= sat(acc_y_d);
        done_q       <= (obj_sel_q == LAST_SEL);
      end
    end
  end

`ifdef FORCE_SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_q;
  always_ff @(posedge clock) begin
    if (reset)                                       ovr_q <= '0;
    else if (step_req && busy_q && ovr_q != 8'hFF)   ovr_q <= ovr_q + 8'd1;
  end
  assign overrun_count = ovr_q;
`else
  assign overrun_count = 8'd0;
`endif

  assign step_busy   = busy_q;
  assign step_done   = done_q;
  assign obj_sel     = obj_sel_q;
  assign other_sel   = other_sel_q;
  assign fc_issue    = fc_issue_q;
  assign x_force_sum = x_sum_q;
  assign y_force_sum = y_sum_q;
  assign commit      = commit_q;
  assign commit_sel  = commit_sel_q;

endmodule

// File: tb/tb_force_step_sequencer.sv
// Directed bench for force_step_sequencer: three instances (latency 1, 0, 3) each driven by a
// small force-calculator model; checks commit timing, sums, saturation, overrun and reset.
module tb_force_step_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   mode   = 0;

  always #5 clock = ~clock;

  typedef struct packed {
    logic              busy, done, commit, issue;
    logic [2:0]        obj_sel, other_sel, csel;
    logic signed [13:0] xs, ys;
    logic [7:0]        ovr;
  } obs_t;

  logic        req0, req1, req2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        iss0, iss1, iss2, com0, com1, com2;
  logic [2:0]  obj0, obj1, obj2, oth0, oth1, oth2, cs0, cs1, cs2;
  logic [13:0] xin0, yin0, xin1, yin1, xin2, yin2;
  logic [13:0] xs0, ys0, xs1, ys1, xs2, ys2;
  logic [13:0] p1x, p1y, p2x, p2y;
  logic [7:0]  ov0, ov1, ov2;

  function automatic logic [13:0] fx(input int m, input logic [2:0] sel);
    case (m)
      0:       return 14'sd1;
      1:       return 14'sd2000;
      default: return {11'b0, sel};
    endcase
  endfunction

  function automatic logic [13:0] fy(input int m, input logic [2:0] sel);
    logic signed [13:0] v;
    v = {11'b0, sel};
    case (m)
      0:       return -14'sd2;
      1:       return -14'sd3000;
      default: return -v;
    endcase
  endfunction

  // Calculator models: latency 1, combinational, and a 3-stage pipe.
  always @(posedge clock) begin
    xin0 <= fx(mode, oth0);
    yin0 <= fy(mode, oth0);
    p1x <= fx(mode, oth2);  p1y <= fy(mode, oth2);
    p2x <= p1x;             p2y <= p1y;
    xin2 <= p2x;            yin2 <= p2y;
  end
  always_comb begin
    xin1 = fx(mode, oth1);
    yin1 = fy(mode, oth1);
  end

  force_step_sequencer #(.FC_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .step_req(req0), .step_busy(busy0), .step_done(done0),
    .obj_sel(obj0), .other_sel(oth0), .fc_issue(iss0), .x_force_in(xin0), .y_force_in(yin0),
    .x_force_sum(xs0), .y_force_sum(ys0), .commit(com0), .commit_sel(cs0), .overrun_count(ov0));

  force_step_sequencer #(.FC_LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset), .step_req(req1), .step_busy(busy1), .step_done(done1),
    .obj_sel(obj1), .other_sel(oth1), .fc_issue(iss1), .x_force_in(xin1), .y_force_in(yin1),
    .x_force_sum(xs1), .y_force_sum(ys1), .commit(com1), .commit_sel(cs1), .overrun_count(ov1));

  force_step_sequencer #(.FC_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .step_req(req2), .step_busy(busy2), .step_done(done2),
    .obj_sel(obj2), .other_sel(oth2), .fc_issue(iss2), .x_force_in(xin2), .y_force_in(yin2),
    .x_force_sum(xs2), .y_force_sum(ys2), .commit(com2), .commit_sel(cs2), .overrun_count(ov2));

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = '{busy0, done0, com0, iss0, obj0, oth0, cs0, xs0, ys0, ov0};
      1:       o = '{busy1, done1, com1, iss1, obj1, oth1, cs1, xs1, ys1, ov1};
      default: o = '{busy2, done2, com2, iss2, obj2, oth2, cs2, xs2, ys2, ov2};
    endcase
    return o;
  endfunction

  task automatic set_req(input int d, input logic v);
    case (d)
      0:       req0 = v;
      1:       req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input int d, input string tag);
    obs_t o;
    o = get_obs(d);
    check({tag, "_busy"}, int'(o.busy), 0);
    check({tag, "_done"}, int'(o.done), 0);
    check({tag, "_commit"}, int'(o.commit), 0);
    check({tag, "_issue"}, int'(o.issue), 0);
    check({tag, "_obj_sel"}, int'(o.obj_sel), 0);
    check({tag, "_other_sel"}, int'(o.other_sel), 0);
    check({tag, "_commit_sel"}, int'(o.csel), 0);
    check({tag, "_x_sum"}, int'(o.xs), 0);
    check({tag, "_y_sum"}, int'(o.ys), 0);
    check({tag, "_overrun"}, int'(o.ovr), 0);
  endtask

  // Request a step on instance d in cycle 0 and watch it for 8*period+3 cycles.
  task automatic run_step(input int d, input int ex, input int ey, input int period, input bit pulses);
    int   cyc, ncommit, nissue, last;
    obs_t o;
    last = 8 * period + 3;
    @(negedge clock);
    set_req(d, 1'b1);
    @(negedge clock);
    cyc = 1; ncommit = 0; nissue = 0;
    while (cyc <= last) begin
      set_req(d, pulses && (cyc == 5 || cyc == 40));
      o = get_obs(d);
      if (cyc == 1) begin
        check("busy_rise", int'(o.busy), 1);
        check("first_obj_sel", int'(o.obj_sel), 0);
        check("first_other_sel", int'(o.other_sel), 0);
        check("first_issue", int'(o.issue), 1);
      end
      if (o.issue) nissue++;
      if (o.commit) begin
        check("commit_cycle", cyc, (ncommit + 1) * period);
        check("commit_sel", int'(o.csel), ncommit);
        check("obj_sel_at_commit", int'(o.obj_sel), ncommit);
        check("x_force_sum", int'(o.xs), ex);
        check("y_force_sum", int'(o.ys), ey);
        check("step_done_at_commit", int'(o.done), (ncommit == 7) ? 1 : 0);
        ncommit++;
      end else if (o.done) begin
        check("step_done_without_commit", 1, 0);
      end
      if (cyc == 8 * period + 1) check("busy_fall", int'(o.busy), 0);
      @(negedge clock);
      cyc++;
    end
    check("commit_count", ncommit, 8);
    check("issue_count", nissue, 64);
    o = get_obs(d);
    check("idle_after_step", int'(o.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   exp_ovr;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_all_zero(0, "reset_lat1");
    check_all_zero(2, "reset_lat3");

    // Constant +1/-2 per issue, with two ignored requests at cycles 5 and 40.
    mode = 0;
    run_step(0, 8, -16, 10, 1'b1);
`ifdef FORCE_SEQ_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif
    o = get_obs(0);
    check("overrun_count", int'(o.ovr), exp_ovr);

    mode = 1;
    run_step(0, 8191, -8192, 10, 1'b0);

    mode = 2;
    run_step(1, 28, -28, 9, 1'b0);
    run_step(2, 28, -28, 12, 1'b0);

    // Reset in the middle of object 3, then a fresh step.
    mode = 0;
    @(negedge clock);
    req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    repeat (32) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero(0, "mid_step_reset");
    repeat (5) @(negedge clock);
    run_step(0, 8, -16, 10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
